// File: rtl/cpu_power_pkg.sv
// rtl/cpu_power_pkg.sv - shared state encodings and default tick constants for CPU power control
package cpu_power_pkg;

  typedef enum logic [2:0] {
    ST_SETTLE   = 3'd0,
    ST_IDLE     = 3'd1,
    ST_BOOT     = 3'd2,
    ST_RUN      = 3'd3,
    ST_COOLDOWN = 3'd4,
    ST_LOCKOUT  = 3'd5
  } sup_state_e;

  typedef logic [15:0] timer_t;
  typedef logic [3:0]  retry_t;

  localparam int unsigned DEF_PRESCALE      = 500;
  localparam int unsigned DEF_STARTUP_TICKS = 100;
  localparam int unsigned DEF_BOOT_TICKS    = 50000;
  localparam int unsigned DEF_HB_TICKS      = 5000;
  localparam int unsigned DEF_OFF_TICKS     = 1000;
  localparam int unsigned DEF_MAX_RETRIES   = 3;

  function automatic retry_t retry_inc(input retry_t r);
    return (r == 4'hF) ? r : r + 4'd1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running divider producing a one-cycle tick every PRESCALE clocks
module tick_prescaler #(
  parameter int unsigned PRESCALE = 500
) (
  input  logic sysclk,
  input  logic sysreset_INV,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge sysclk or negedge sysreset_INV) begin
    if (!sysreset_INV) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cpu_power_supervisor.sv
// rtl/cpu_power_supervisor.sv - gates the power sequencer enable: settle, boot/heartbeat watchdogs, fault retry, lockout
module cpu_power_supervisor
  import cpu_power_pkg::*;
#(
  parameter int unsigned PRESCALE      = DEF_PRESCALE,
  parameter int unsigned STARTUP_TICKS = DEF_STARTUP_TICKS,
  parameter int unsigned BOOT_TICKS    = DEF_BOOT_TICKS,
  parameter int unsigned HB_TICKS      = DEF_HB_TICKS,
  parameter int unsigned OFF_TICKS     = DEF_OFF_TICKS,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic       sysclk,
  input  logic       sysreset_INV,
  input  logic       board_enable,
  input  logic       cpu_heartbeat,
  input  logic       pmic_fault_INV,
  input  logic       clear_lockout,
  output logic       cpu_seq_enable,
  output logic [2:0] sup_state,
  output logic [3:0] retry_count,
  output logic       lockout
);

  localparam timer_t STARTUP_T = timer_t'(STARTUP_TICKS);
  localparam timer_t BOOT_T    = timer_t'(BOOT_TICKS);
  localparam timer_t HB_T      = timer_t'(HB_TICKS);
  localparam timer_t OFF_T     = timer_t'(OFF_TICKS);
  localparam retry_t MAX_R     = retry_t'(MAX_RETRIES);

  sup_state_e state_q, next_state;
  timer_t     timer_q;
  retry_t     retry_q;
  logic       tick;
  logic       hb_s1, hb_s2, hb_s3, flt_s1, flt_s2;
  logic       hb_edge, fault, retry_bump, hb_restart;
  logic       enable_q, lockout_q;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .sysclk       (sysclk),
    .sysreset_INV (sysreset_INV),
    .tick         (tick)
  );

  always_ff @(posedge sysclk or negedge sysreset_INV) begin
    if (!sysreset_INV) begin
      hb_s1  <= 1'b0;
      hb_s2  <= 1'b0;
      hb_s3  <= 1'b0;
      flt_s1 <= 1'b0;
      flt_s2 <= 1'b0;
    end else begin
      hb_s1  <= cpu_heartbeat;
      hb_s2  <= hb_s1;
      hb_s3  <= hb_s2;
      flt_s1 <= pmic_fault_INV;
      flt_s2 <= flt_s1;
    end
  end

  assign hb_edge = hb_s2 ^ hb_s3;
  assign fault   = !flt_s2;

  // Priority: board drop, then fault, then heartbeat, then timeout.
  always_comb begin
    next_state = state_q;
    retry_bump = 1'b0;
    hb_restart = 1'b0;
    case (state_q)
      ST_SETTLE:   if (timer_q == STARTUP_T) next_state = ST_IDLE;
      ST_IDLE:     if (board_enable && !fault) next_state = ST_BOOT;
      ST_BOOT: begin
        if (!board_enable) begin
          next_state = ST_COOLDOWN;
        end else if (fault || (!hb_edge && timer_q == BOOT_T)) begin
          next_state = ST_COOLDOWN;
          retry_bump = 1'b1;
        end else if (hb_edge) begin
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!board_enable) begin
          next_state = ST_COOLDOWN;
        end else if (fault || (!hb_edge && timer_q == HB_T)) begin
          next_state = ST_COOLDOWN;
          retry_bump = 1'b1;
        end else if (hb_edge) begin
          hb_restart = 1'b1;
        end
      end
      ST_COOLDOWN: begin
        if (timer_q == OFF_T) next_state = (retry_q >= MAX_R) ? ST_LOCKOUT : ST_IDLE;
      end
      ST_LOCKOUT:  if (clear_lockout) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge sysreset_INV) begin
    if (!sysreset_INV) begin
      state_q   <= ST_SETTLE;
      timer_q   <= '0;
      retry_q   <= '0;
      enable_q  <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= next_state;
      enable_q  <= (next_state == ST_BOOT) || (next_state == ST_RUN);
      lockout_q <= (next_state == ST_LOCKOUT);
      if (next_state != state_q || hb_restart) begin
        timer_q <= '0;
      end else if (tick && timer_q != '1) begin
        timer_q <= timer_q + 16'd1;
      end
      // Leaving lockout or a clean user shutdown forgives earlier failures.
      if (retry_bump) begin
        retry_q <= retry_inc(retry_q);
      end else if (next_state == ST_IDLE && state_q != ST_IDLE &&
                   (!board_enable || state_q == ST_LOCKOUT)) begin
        retry_q <= '0;
      end
    end
  end

  assign cpu_seq_enable = enable_q;
  assign lockout        = lockout_q;
  assign sup_state      = state_q;
  assign retry_count    = retry_q;

endmodule

// File: tb/tb_cpu_power_supervisor.sv
// tb/tb_cpu_power_supervisor.sv - scoreboard bench for cpu_power_supervisor
module tb_cpu_power_supervisor;

  localparam int PS = 4;

  logic       sysclk, sysreset_INV, board_enable, cpu_heartbeat, pmic_fault_INV, clear_lockout;
  logic       cpu_seq_enable, lockout;
  logic [2:0] sup_state;
  logic [3:0] retry_count;

  typedef struct {
    logic en;
    bit   from_stim;
    int   clr;
    int   n;
    int   post;
    int   st;
    int   rt;
  } evt_t;

  evt_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc;
  int   stim_cyc = 0;
  int   last_evt;
  int   hb_last = 0;
  bit   hb_on = 0;
  bit   mon_on = 1;
  logic prev_en;

  cpu_power_supervisor #(
    .PRESCALE(4), .STARTUP_TICKS(10), .BOOT_TICKS(50),
    .HB_TICKS(20), .OFF_TICKS(15), .MAX_RETRIES(2)
  ) dut (
    .sysclk         (sysclk),
    .sysreset_INV   (sysreset_INV),
    .board_enable   (board_enable),
    .cpu_heartbeat  (cpu_heartbeat),
    .pmic_fault_INV (pmic_fault_INV),
    .clear_lockout  (clear_lockout),
    .cpu_seq_enable (cpu_seq_enable),
    .sup_state      (sup_state),
    .retry_count    (retry_count),
    .lockout        (lockout)
  );

  initial begin
    sysclk = 0;
    forever #5 sysclk = ~sysclk;
  end

  always @(posedge sysclk or negedge sysreset_INV) begin
    if (!sysreset_INV) cyc <= 0;
    else               cyc <= cyc + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Timer cleared at rc+clr; n-tick timeout fires one edge after the n-th tick; post extra edges.
  function automatic int exp_cyc(input int rc, input int clr, input int n, input int post);
    int first;
    if (n == 0) return rc + clr + post;
    first = ((rc + clr) / PS + 1) * PS;
    return first + PS * (n - 1) + 1 + post;
  endfunction

  task automatic push_evt(input logic en, input bit fs, input int clr, input int n,
                          input int post, input int st, input int rt);
    evt_t e;
    e.en = en; e.from_stim = fs; e.clr = clr; e.n = n; e.post = post; e.st = st; e.rt = rt;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge sysclk);
    check("sb_drain", sb.size(), 0);
  endtask

  always @(negedge sysclk) begin
    evt_t e;
    if (mon_on && sysreset_INV && cpu_seq_enable !== prev_en) begin
      if (sb.size() == 0) begin
        check("unexpected_en", cpu_seq_enable, prev_en);
      end else begin
        e = sb.pop_front();
        check("en_lat", cyc, exp_cyc(e.from_stim ? stim_cyc : last_evt, e.clr, e.n, e.post));
        check("en_val", cpu_seq_enable, e.en);
        check("en_state", sup_state, e.st);
        check("en_retry", retry_count, e.rt);
        check("en_lockout", lockout, 0);
      end
      last_evt <= cyc;
    end
    prev_en <= cpu_seq_enable;
  end

  initial begin
    int hb_cnt;
    cpu_heartbeat = 0;
    hb_cnt = 0;
    forever begin
      @(negedge sysclk);
      if (hb_on) begin
        hb_cnt++;
        if (hb_cnt == 10 * PS) begin
          cpu_heartbeat = ~cpu_heartbeat;
          hb_last = cyc;
          hb_cnt = 0;
        end
      end else begin
        hb_cnt = 0;
      end
    end
  end

  initial begin
    prev_en = 0;
    last_evt = 0;
    sysreset_INV = 0;
    board_enable = 1;
    pmic_fault_INV = 1;
    clear_lockout = 0;
    repeat (3) @(negedge sysclk);
    check("rst_en", cpu_seq_enable, 0);
    check("rst_state", sup_state, 0);
    check("rst_retry", retry_count, 0);
    check("rst_lockout", lockout, 0);

    stim_cyc = 0;
    push_evt(1, 1, 0, 10, 1, 2, 0);
    sysreset_INV = 1;
    wait_drain(100);

    hb_on = 1;
    repeat (1000 * PS) @(negedge sysclk);
    check("run_state", sup_state, 3);
    check("run_retry", retry_count, 0);
    check("run_en", cpu_seq_enable, 1);

    hb_on = 0;
    @(negedge sysclk);
    stim_cyc = hb_last;
    push_evt(0, 1, 3, 20, 0, 4, 1);
    push_evt(1, 0, 0, 15, 1, 2, 1);
    wait_drain(300);
    hb_on = 1;
    repeat (200) @(negedge sysclk);
    check("rerun_state", sup_state, 3);

    board_enable = 0;
    stim_cyc = cyc;
    push_evt(0, 1, 1, 0, 0, 4, 1);
    push_evt(1, 0, 0, 15, 1, 2, 1);
    repeat (5 * PS) @(negedge sysclk);
    board_enable = 1;
    wait_drain(300);
    repeat (100) @(negedge sysclk);
    check("drop_run_state", sup_state, 3);

    board_enable = 0;
    stim_cyc = cyc;
    push_evt(0, 1, 1, 0, 0, 4, 1);
    hb_on = 0;
    wait_drain(20);
    repeat (100) @(negedge sysclk);
    check("clean_idle_state", sup_state, 1);
    check("clean_idle_retry", retry_count, 0);
    board_enable = 1;
    stim_cyc = cyc;
    push_evt(1, 1, 1, 0, 0, 2, 0);
    wait_drain(20);

    push_evt(0, 0, 0, 50, 0, 4, 1);
    push_evt(1, 0, 0, 15, 1, 2, 1);
    push_evt(0, 0, 0, 50, 0, 4, 2);
    wait_drain(1000);
    for (int i = 0; i < 300 && !lockout; i++) @(negedge sysclk);
    check("lockout_seen", lockout, 1);
    check("lockout_lat", cyc, exp_cyc(last_evt, 0, 15, 0));
    check("lockout_state", sup_state, 5);
    check("lockout_retry", retry_count, 2);
    repeat (200) @(negedge sysclk);
    check("lockout_hold", sup_state, 5);
    check("lockout_en", cpu_seq_enable, 0);

    clear_lockout = 1;
    stim_cyc = cyc;
    push_evt(1, 1, 2, 0, 0, 2, 0);
    @(negedge sysclk);
    clear_lockout = 0;
    wait_drain(20);

    repeat (10) @(negedge sysclk);
    pmic_fault_INV = 0;
    stim_cyc = cyc;
    push_evt(0, 1, 3, 0, 0, 4, 1);
    wait_drain(20);
    repeat (150) @(negedge sysclk);
    check("fault_idle_state", sup_state, 1);
    check("fault_idle_retry", retry_count, 1);
    check("fault_idle_en", cpu_seq_enable, 0);
    pmic_fault_INV = 1;
    stim_cyc = cyc;
    push_evt(1, 1, 3, 0, 0, 2, 1);
    wait_drain(20);

    mon_on = 0;
    @(negedge sysclk);
    #2 sysreset_INV = 0;
    #1;
    check("async_rst_en", cpu_seq_enable, 0);
    check("async_rst_state", sup_state, 0);
    check("async_rst_retry", retry_count, 0);
    check("async_rst_lockout", lockout, 0);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
